// File: rtl/rob_alloc_if.sv
// rtl/rob_alloc_if.sv - dispatch/commit handshake bundle between dispatch logic and the ROB entry allocator
interface rob_alloc_if #(
    parameter int ENT_SEL = 6
);
    logic               dp_req_i;
    logic               stall_dp_i;
    logic               alloc_o;
    logic [ENT_SEL-1:0] alloc_ptr_o;
    logic               stall_o;
    logic               com_en_i;
    logic [ENT_SEL-1:0] com_ptr_i;
    logic               flush_i;
    logic [ENT_SEL:0]   freenum_o;
    logic               full_o;
    logic               empty_o;
    logic               err_o;

    modport master (
        output dp_req_i, stall_dp_i, com_en_i, com_ptr_i, flush_i,
        input  alloc_o, alloc_ptr_o, stall_o, freenum_o, full_o, empty_o, err_o
    );

    modport slave (
        input  dp_req_i, stall_dp_i, com_en_i, com_ptr_i, flush_i,
        output alloc_o, alloc_ptr_o, stall_o, freenum_o, full_o, empty_o, err_o
    );
endinterface

// File: rtl/rob_alloc.sv
// rtl/rob_alloc.sv - single-way in-order ROB entry allocator with commit reclaim and flush
module rob_alloc #(
    parameter int ENT_NUM = 64,
    parameter int ENT_SEL = 6
) (
    input  logic         clk,
    input  logic         reset,
    rob_alloc_if.slave   bus
);
    localparam logic [ENT_SEL:0]   FULL_CNT = (ENT_SEL+1)'(ENT_NUM);
    localparam logic [ENT_SEL:0]   CNT_ONE  = 1;
    localparam logic [ENT_SEL-1:0] PTR_ONE  = 1;

    logic [ENT_SEL-1:0] head;
    logic [ENT_SEL-1:0] tail;
    logic [ENT_SEL:0]   count;
    logic               err;

    logic               full;
    logic               empty;
    logic               alloc;
    logic               com_ok;
    logic               com_bad;
    logic [ENT_SEL-1:0] head_nxt;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // full is registered, so a same-cycle commit cannot unblock allocation
    assign alloc    = bus.dp_req_i & ~bus.stall_dp_i & ~full & ~bus.flush_i;
    assign com_ok   = bus.com_en_i & ~empty;
    assign com_bad  = bus.com_en_i & (empty | (bus.com_ptr_i != head));
    assign head_nxt = com_ok ? head + PTR_ONE : head;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            head <= head_nxt;
            // the commit is older than the flush, so tail snaps to the post-commit head
            if (bus.flush_i) begin
                tail  <= head_nxt;
                count <= '0;
            end else begin
                if (alloc)
                    tail <= tail + PTR_ONE;
                case ({alloc, com_ok})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
            if (com_bad)
                err <= 1'b1;
        end
    end

    assign bus.alloc_o     = alloc;
    assign bus.alloc_ptr_o = tail;
    assign bus.stall_o     = bus.dp_req_i & (full | bus.stall_dp_i);
    assign bus.freenum_o   = FULL_CNT - count;
    assign bus.full_o      = full;
    assign bus.empty_o     = empty;
    assign bus.err_o       = err;
endmodule

// File: doc/rob_alloc.md
Name: rob_alloc

Overview:
- Single-way ROB/RRF entry allocator that sits directly upstream of the ROB in the dispatch stage.
- Hands out the next free entry tag, which drives the ROB `dp1_addr_i` and `dp1_i`.
- Tracks occupancy and back-pressures dispatch when full.
- Reclaims entries in order as the ROB commits them and supports a full flush on mispredict.

Parameters:
- ENT_NUM, 64, number of ROB entries; must be a power of two.
- ENT_SEL, 6, tag width, equal to log2(ENT_NUM); matches `ROB_SEL`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dp_req_i  in  1  decoded instruction is valid and wants an entry this cycle.
- stall_dp_i  in  1  other dispatch resources (RS, LSQ) are unavailable; blocks allocation.
- alloc_o  out  1  entry allocated this cycle; drives ROB `dp1_i`.
- alloc_ptr_o  out  ENT_SEL  tag of the entry being allocated; drives ROB `dp1_addr_i`.
- stall_o  out  1  `dp_req_i & (full_o | stall_dp_i)`; stalls the decode stage.
- com_en_i  in  1  ROB retired one entry this cycle (ROB `arfwe_1_o` qualified by commit).
- com_ptr_i  in  ENT_SEL  tag retired this cycle (ROB `commit_ptr_1_o`).
- flush_i  in  1  discard all uncommitted entries.
- freenum_o  out  ENT_SEL+1  number of free entries, 0..ENT_NUM.
- full_o  out  1  count == ENT_NUM.
- empty_o  out  1  count == 0.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- State: head[ENT_SEL-1:0], tail[ENT_SEL-1:0], count[ENT_SEL:0], err.
- Reset values: head=0, tail=0, count=0, err=0.
  - Resulting outputs: freenum_o=ENT_NUM, full_o=0, empty_o=1, alloc_o=0 (when dp_req_i=0), alloc_ptr_o=0, err_o=0.
- Reset asserted mid-operation overrides every other input in that cycle.
- Outputs:
  - alloc_ptr_o = tail (registered).
  - alloc_o = dp_req_i & ~stall_dp_i & ~full_o & ~flush_i (combinational, zero latency).
  - The ROB writes the entry at the same edge that tail advances.
  - freenum_o = ENT_NUM - count; full_o and empty_o decode from registered count.
- Allocate (alloc_o=1): tail <= tail+1 with natural modulo-ENT_NUM wrap (63 -> 0); count +1.
- Commit (com_en_i=1, count>0): head <= head+1 with wrap; count -1.
- Simultaneous allocate and commit: both pointers advance; count unchanged.
- Full:
  - A commit in the same cycle does not unblock allocation.
  - full_o is registered, so the freed slot becomes allocatable next cycle.
- Flush (flush_i=1) has priority over allocation:
  - alloc_o is forced 0.
  - If com_en_i is set, head advances first.
  - Then tail <= new head and count <= 0.
  - A same-cycle commit still retires, because it is older than the flush.
- Error (err_o sticky, cleared only by reset); set on:
  - com_en_i=1 with count==0 (the commit is ignored, pointers unchanged);
  - com_en_i=1 with com_ptr_i != head (the commit is still applied).
- Tags are issued strictly in order and no tag is reissued while live. Invariant: (tail - head) mod ENT_NUM == count mod ENT_NUM.

Test Plan:
- Reset, then dp_req_i=1 for 3 cycles with stall_dp_i=0 -> alloc_o=1 each cycle; alloc_ptr_o=0,1,2; freenum_o=61; empty_o=0.
- 64 consecutive allocations with no commit -> full_o=1 and freenum_o=0 after the 64th. On the 65th request: alloc_o=0, stall_o=1, alloc_ptr_o=0 (wrapped).
- From full, com_en_i=1, com_ptr_i=0 together with dp_req_i=1 -> no allocation that cycle; next cycle full_o=0, alloc_o=1, alloc_ptr_o=0, head=1.
- Entries 5..9 live (head=5, tail=10). Assert flush_i with com_en_i=1, com_ptr_i=5 and dp_req_i=1 -> alloc_o=0; next cycle head=6, tail=6, empty_o=1, freenum_o=64.
- com_en_i=1 while empty -> err_o=1 next cycle and pointers unchanged. Separately, com_ptr_i=7 when head=2 -> err_o=1 and head=3. err_o stays 1 until reset.
- stall_dp_i=1 with dp_req_i=1 and entries free -> alloc_o=0, stall_o=1, tail and count unchanged; releasing stall_dp_i -> allocation resumes at the same tag.
